// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule FSM state type and rotate helper.
package sha256_pkg;

  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_ROUNDS = 64;

  localparam int SIG0_ROT_A = 7;
  localparam int SIG0_ROT_B = 18;
  localparam int SIG0_SHR   = 3;
  localparam int SIG1_ROT_A = 17;
  localparam int SIG1_ROT_B = 19;
  localparam int SIG1_SHR   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  function automatic logic [SHA256_WORD_W-1:0] rotr(input logic [SHA256_WORD_W-1:0] x,
                                                     input int n);
    return (x >> n) | (x << (SHA256_WORD_W - n));
  endfunction

endpackage

// File: rtl/sigma0_func_schedule.sv
// Message-schedule small sigma0: ROTR7 ^ ROTR18 ^ SHR3, purely combinational.
module sigma0_func_schedule
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] x,
  output logic [SHA256_WORD_W-1:0] y
);

  assign y = rotr(x, SIG0_ROT_A) ^ rotr(x, SIG0_ROT_B) ^ (x >> SIG0_SHR);

endmodule

// File: rtl/sigma1_func_schedule.sv
// Message-schedule small sigma1: ROTR17 ^ ROTR19 ^ SHR10, purely combinational.
module sigma1_func_schedule
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] x,
  output logic [SHA256_WORD_W-1:0] y
);

  assign y = rotr(x, SIG1_ROT_A) ^ rotr(x, SIG1_ROT_B) ^ (x >> SIG1_SHR);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words into a sliding window, then
// streams W[0..NUM_ROUNDS-1] while computing W[t+16] into the window tail.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = SHA256_ROUNDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [SHA256_WORD_W-1:0] msg_word_in,
  input  logic                     msg_word_valid,
  output logic                     msg_word_ready,
  output logic [SHA256_WORD_W-1:0] w_out,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [5:0]               t_out,
  output logic                     busy,
  output logic                     done
);

  localparam logic [5:0] T_LAST = 6'(NUM_ROUNDS - 1);

  sched_state_e             state;
  logic [SHA256_WORD_W-1:0] r [16];
  logic [3:0]               load_cnt;
  logic [5:0]               t;
  logic [SHA256_WORD_W-1:0] s0;
  logic [SHA256_WORD_W-1:0] s1;
  logic [SHA256_WORD_W-1:0] w_next;
  logic                     load_fire;
  logic                     emit_fire;

  sigma0_func_schedule u_sigma0 (.x(r[1]),  .y(s0));
  sigma1_func_schedule u_sigma1 (.x(r[14]), .y(s1));

  // W[t+16] from the current window; carries beyond 32 bits drop naturally.
  assign w_next = s1 + r[9] + s0 + r[0];

  assign load_fire = (state == LOAD) && msg_word_valid;
  assign emit_fire = (state == EMIT) && w_ready;

  assign msg_word_ready = (state == LOAD);
  assign w_valid        = (state == EMIT);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign w_out          = r[0];
  assign t_out          = t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      load_cnt <= '0;
      t        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            load_cnt <= '0;
          end
        end
        LOAD: begin
          if (load_fire) begin
            load_cnt <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              state <= EMIT;
              t     <= '0;
            end
          end
        end
        EMIT: begin
          if (emit_fire) begin
            t <= t + 6'd1;
            if (t == T_LAST) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Window: random-access writes while loading, shift-and-append while emitting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
    end else if (load_fire) begin
      r[load_cnt] <= msg_word_in;
    end else if (emit_fire) begin
      for (int i = 0; i < 15; i++) r[i] <= r[i+1];
      r[15] <= w_next;
    end
  end

endmodule
